monster_line_renderer: RTL and testbench
========================================

Name: monster_line_renderer

Overview:
Downstream consumer of the game state machine's packed state_monsters bus. It sits between that bus and the VGA pixel path, in the pixel clock domain. Once per frame it snapshots the 12 monster slots. During each horizontal blank it scans the slots and builds a small per-line sprite list for the next line. During active video it emits a registered per-pixel monster hit, direction and sprite texel coordinates to the colour/ROM stage.

Parameters:
MONSTERS, 12, number of 19-bit slots on the state bus.
MAX_PER_LINE, 4, sprite list capacity per scanline.
SCALE_SHIFT, 1, pixel coordinate = game coordinate << SCALE_SHIFT.
SPRITE_W, 16, sprite width in pixels (power of two).
SPRITE_H, 16, sprite height in pixels (power of two).
H_ACTIVE / H_TOTAL, 640 / 800, horizontal timing.
V_ACTIVE / V_TOTAL, 480 / 525, vertical timing.

Ports:
clk_vga  in  1  pixel clock.
rst_n  in  1  asynchronous active-low reset.
state_monsters  in  228  12 slots of 19 bits. Per slot: bit0 = valid, [2:1] = dir, [10:3] = x, [18:11] = y.
h_cnt  in  10  current pixel column from the sync generator.
v_cnt  in  10  current line from the sync generator.
monster_hit  out  1  current pixel is covered by a monster.
monster_dir  out  2  dir of the covering monster.
monster_col  out  4  column within the sprite, log2(SPRITE_W) bits.
monster_row  out  4  row within the sprite, log2(SPRITE_H) bits.
line_overflow  out  1  sticky per frame: some line had more than MAX_PER_LINE candidates.

Behaviour:
- Reset (async, any time including mid-line):
  - all outputs 0;
  - snapshot, eval list and display list cleared;
  - FSM to IDLE.
- Snapshot:
  - When v_cnt==V_TOTAL-1 and h_cnt==H_ACTIVE, copy state_monsters into a shadow register and clear line_overflow.
  - Changes to the bus mid-frame have no effect until the next snapshot.
- Evaluation FSM:
  - States: IDLE, SCAN, DONE.
  - IDLE -> SCAN when h_cnt==H_ACTIVE. Target line = v_cnt+1, wrapping to 0 after V_TOTAL-1. Eval list is cleared.
  - SCAN visits one slot per cycle, index 0..MONSTERS-1 ascending.
  - Slot i is a candidate if valid and y_px <= target < y_px+SPRITE_H. Comparison uses 10-bit unsigned arithmetic, with y_px = {2'b0, y} << SCALE_SHIFT.
  - A candidate is appended as {x_px, dir, row = target - y_px}.
  - If the list is already full, the candidate is dropped and line_overflow is set.
  - After slot MONSTERS-1, go to DONE. DONE -> IDLE when h_cnt==H_TOTAL-1.
- List swap: at h_cnt==H_TOTAL-1 the eval list is copied to the display list.
  - Evaluation takes MONSTERS+1 cycles, which is well inside the blank interval.
  - Lines with target >= V_ACTIVE produce an empty list.
- Display, with one cycle of registered latency relative to h_cnt:
  - monster_hit=1 when h_cnt < H_ACTIVE, v_cnt < V_ACTIVE and some display entry has x_px <= h_cnt < x_px+SPRITE_W.
  - The lowest list position (lowest slot index) wins.
  - monster_col = h_cnt - x_px; monster_row and monster_dir come from the winning entry.
  - When there is no hit, monster_hit, monster_dir, monster_col and monster_row are all 0.
- Boundaries:
  - Sprites extending past H_ACTIVE are clipped.
  - x_px+SPRITE_W is computed in 11 bits, so there is no wrap.
  - An entry count of exactly MAX_PER_LINE does not set overflow.

Optional Feature:
Macro LINE_OVERFLOW_STAT_EN.
- Defined:
  - Adds output overflow_lines [7:0]: the saturating count of lines in the previous frame that dropped at least one candidate.
  - It is latched at the frame snapshot instant; the internal counter is cleared there too.
  - Reset value 0.
- Undefined: the port and its counter are absent. line_overflow behaviour is unchanged in both cases.

Decomposition:
- Shared package fury_pkg holds:
  - MONSTERS and SLOT_W=19;
  - slot field offsets (VALID=0, DIR_LO=1, X_LO=3, Y_LO=11);
  - dir encodings (UP=0, DOWN=1, LEFT=2, RIGHT=3);
  - the VGA timing constants;
  - the list-entry struct.
- One sub-module, monster_slot_unpack: a combinational decode of one 19-bit slot into valid/dir/x_px/y_px. It is instantiated once on the SCAN mux output.

Test Plan:
- Slot0 = valid, dir 0, x 73, y 167 (x_px 146, y_px 334); after a frame snapshot:
  - lines 334..349, h_cnt 146..161: hit=1 one cycle later, dir 0, col 0..15, row = line-334;
  - h_cnt 162 and line 350: hit=0.
- Five valid slots 0..4 with y 105 and x 14, 34, 54, 91, 111 -> on line 210:
  - slots 0..3 render and slot 4 (x_px 222) does not;
  - line_overflow=1, cleared at the next snapshot when the bus is fixed.
- Slots 2 and 5 both at x 73, y 105, dirs 3 and 2 -> overlapping pixels report dir 3.
- Change the bus mid-frame (move slot0 to y 147) -> the remainder of the frame is unchanged; the next frame renders at line 294.
- Drop rst_n at line 340, h_cnt 150 -> outputs 0 asynchronously. After release, no hits until the next snapshot.
- With LINE_OVERFLOW_STAT_EN, the overflow setup of test 2 held for a frame -> overflow_lines=16 after the following snapshot.

Source files
------------

// File: rtl/fury_pkg.sv
// -----------------------------------------------------------------------------
// fury_pkg
// Shared definitions for the monster rendering path: the layout of the packed
// state_monsters bus, the direction encodings, VGA timing constants, sprite
// geometry and the per-scanline sprite list entry.
// -----------------------------------------------------------------------------
package fury_pkg;

  // Monster state bus layout: MONSTERS slots of SLOT_W bits each.
  localparam int MONSTERS = 12;
  localparam int SLOT_W   = 19;

  // Field offsets inside one slot.
  localparam int VALID  = 0;
  localparam int DIR_LO = 1;
  localparam int X_LO   = 3;
  localparam int Y_LO   = 11;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // VGA timing, sized to match the 10-bit h_cnt / v_cnt inputs.
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_LAST   = 10'd799;  // H_TOTAL - 1
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_LAST   = 10'd524;  // V_TOTAL - 1

  // Sprite geometry and scanline list capacity.
  localparam int MAX_PER_LINE = 4;
  localparam int SCALE_SHIFT  = 1;
  localparam int SPRITE_W     = 16;
  localparam int SPRITE_H     = 16;
  localparam int COL_W        = $clog2(SPRITE_W);
  localparam int ROW_W        = $clog2(SPRITE_H);
  localparam int CNT_W        = $clog2(MAX_PER_LINE + 1);
  localparam int LIST_IDX_W   = $clog2(MAX_PER_LINE);
  localparam int SLOT_IDX_W   = $clog2(MONSTERS);

  // One sprite scheduled for a scanline: pixel x, facing and row in sprite.
  typedef struct packed {
    logic [9:0]       x_px;
    logic [1:0]       dir;
    logic [ROW_W-1:0] row;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/monster_slot_unpack.sv
// -----------------------------------------------------------------------------
// monster_slot_unpack
// Purely combinational decode of one 19-bit monster slot into its fields, with
// the game coordinates scaled to pixel coordinates.
// Ports:
//   slot   in  SLOT_W  packed slot {y, x, dir, valid}
//   valid  out 1       slot holds a live monster
//   dir    out 2       facing (dir_e encoding)
//   x_px   out 10      x << SCALE_SHIFT
//   y_px   out 10      y << SCALE_SHIFT
// -----------------------------------------------------------------------------
module monster_slot_unpack
  import fury_pkg::*;
(
  input  logic [SLOT_W-1:0] slot,
  output logic              valid,
  output logic [1:0]        dir,
  output logic [9:0]        x_px,
  output logic [9:0]        y_px
);

  assign valid = slot[VALID];
  assign dir   = slot[DIR_LO +: 2];
  assign x_px  = {2'b00, slot[X_LO +: 8]} << SCALE_SHIFT;
  assign y_px  = {2'b00, slot[Y_LO +: 8]} << SCALE_SHIFT;

endmodule

// File: rtl/monster_line_renderer.sv
// -----------------------------------------------------------------------------
// monster_line_renderer
// Snapshots the monster state bus once per frame, builds a sprite list for the
// next scanline during horizontal blank, and emits a registered per-pixel
// monster hit with direction and texel coordinates during active video.
// Optional feature: define LINE_OVERFLOW_STAT_EN to add overflow_lines, the
// saturating count of lines in the previous frame that dropped a candidate.
// Ports:
//   clk_vga         in  1    pixel clock
//   rst_n           in  1    asynchronous active-low reset
//   state_monsters  in  228  12 packed slots of 19 bits
//   h_cnt, v_cnt    in  10   current pixel column / line
//   monster_hit     out 1    pixel covered by a monster (1 cycle latency)
//   monster_dir     out 2    dir of the covering monster
//   monster_col     out 4    column inside the sprite
//   monster_row     out 4    row inside the sprite
//   line_overflow   out 1    sticky per frame: a line had too many candidates
//   overflow_lines  out 8    (LINE_OVERFLOW_STAT_EN only) lines that dropped
// -----------------------------------------------------------------------------
module monster_line_renderer
  import fury_pkg::*;
(
  input  logic                       clk_vga,
  input  logic                       rst_n,
  input  logic [MONSTERS*SLOT_W-1:0] state_monsters,
  input  logic [9:0]                 h_cnt,
  input  logic [9:0]                 v_cnt,
  output logic                       monster_hit,
  output logic [1:0]                 monster_dir,
  output logic [COL_W-1:0]           monster_col,
  output logic [ROW_W-1:0]           monster_row,
  output logic                       line_overflow
`ifdef LINE_OVERFLOW_STAT_EN
  ,
  output logic [7:0]                 overflow_lines
`endif
);

  localparam logic [SLOT_IDX_W-1:0] LAST_IDX = SLOT_IDX_W'(MONSTERS - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(MAX_PER_LINE);

  scan_state_e                         state, state_nxt;
  logic [MONSTERS-1:0][SLOT_W-1:0]     shadow;
  logic [SLOT_IDX_W-1:0]               scan_idx;
  logic [9:0]                          target;
  entry_t [MAX_PER_LINE-1:0]           eval_list, disp_list;
  logic [CNT_W-1:0]                    eval_cnt, disp_cnt;

  logic       snap, scan_start, list_full, cand, drop;
  logic       s_valid;
  logic [1:0] s_dir;
  logic [9:0] s_x_px, s_y_px, y_end;
  entry_t     new_entry;

  assign snap       = (v_cnt == V_LAST) && (h_cnt == H_ACTIVE);
  assign scan_start = (state == ST_IDLE) && (h_cnt == H_ACTIVE);
  assign list_full  = (eval_cnt == FULL_CNT);

  // Single decoder on the slot mux output; SCAN walks it over the shadow copy.
  monster_slot_unpack u_unpack (
    .slot  (shadow[scan_idx]),
    .valid (s_valid),
    .dir   (s_dir),
    .x_px  (s_x_px),
    .y_px  (s_y_px)
  );

  // y_px tops out at 510, so y_px + SPRITE_H still fits in 10 bits.
  assign y_end = s_y_px + 10'(SPRITE_H);
  // Lines below the active area never collect sprites.
  assign cand  = (state == ST_SCAN) && s_valid && (target < V_ACTIVE) &&
                 (s_y_px <= target) && (target < y_end);
  assign drop  = cand && list_full;

  assign new_entry.x_px = s_x_px;
  assign new_entry.dir  = s_dir;
  assign new_entry.row  = ROW_W'(target - s_y_px);

  // ---------------------------------------------------------------------------
  // Evaluation FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt; no latch.
    state_nxt = state;
    case (state)
      ST_IDLE: if (h_cnt == H_ACTIVE)  state_nxt = ST_SCAN;
      ST_SCAN: if (scan_idx == LAST_IDX) state_nxt = ST_DONE;
      ST_DONE: if (h_cnt == H_LAST)    state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the sprite lists and snapshot are plain flops, not RAM, so they are
  // cleared on reset; no stale sprite can appear after a mid-frame reset.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      scan_idx  <= '0;
      target    <= '0;
      eval_list <= '0;
      eval_cnt  <= '0;
      disp_list <= '0;
      disp_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked logic so every register
      // samples pre-edge values regardless of statement order.
      if (snap) shadow <= state_monsters;

      if (scan_start) begin
        scan_idx  <= '0;
        target    <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        eval_list <= '0;
        eval_cnt  <= '0;
      end else if (state == ST_SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        if (cand && !list_full) begin
          eval_list[eval_cnt[LIST_IDX_W-1:0]] <= new_entry;
          eval_cnt <= eval_cnt + 1'b1;
        end
      end

      if (h_cnt == H_LAST) begin
        disp_list <= eval_list;
        disp_cnt  <= eval_cnt;
      end
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n)     line_overflow <= 1'b0;
    else if (snap)  line_overflow <= 1'b0;
    else if (drop)  line_overflow <= 1'b1;
  end

`ifdef LINE_OVERFLOW_STAT_EN
  logic       line_dropped;
  logic [7:0] ovf_cnt;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      line_dropped   <= 1'b0;
      ovf_cnt        <= '0;
      overflow_lines <= '0;
    end else begin
      if (scan_start)  line_dropped <= 1'b0;
      else if (drop)   line_dropped <= 1'b1;

      if (snap) begin
        overflow_lines <= ovf_cnt;
        ovf_cnt        <= '0;
      end else if ((state == ST_SCAN) && (scan_idx == LAST_IDX) &&
                   (line_dropped || drop) && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Display: per-pixel lookup in the current line's list, registered output.
  // ---------------------------------------------------------------------------
  logic                 hit_nxt;
  logic [1:0]           dir_nxt;
  logic [COL_W-1:0]     col_nxt;
  logic [ROW_W-1:0]     row_nxt;

  always_comb begin
    hit_nxt = 1'b0;
    dir_nxt = '0;
    col_nxt = '0;
    row_nxt = '0;
    if ((h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)) begin
      // Walk from the highest position down so the lowest-index entry, which
      // came from the lowest slot, is the last writer and wins.
      for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
        if ((CNT_W'(i) < disp_cnt) &&
            ({1'b0, h_cnt} >= {1'b0, disp_list[i].x_px}) &&
            ({1'b0, h_cnt} <  ({1'b0, disp_list[i].x_px} + 11'(SPRITE_W)))) begin
          hit_nxt = 1'b1;
          dir_nxt = disp_list[i].dir;
          col_nxt = COL_W'(h_cnt - disp_list[i].x_px);
          row_nxt = disp_list[i].row;
        end
      end
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      monster_hit <= 1'b0;
      monster_dir <= '0;
      monster_col <= '0;
      monster_row <= '0;
    end else begin
      monster_hit <= hit_nxt;
      monster_dir <= dir_nxt;
      monster_col <= col_nxt;
      monster_row <= row_nxt;
    end
  end

endmodule

// File: tb/tb_monster_line_renderer.sv
// -----------------------------------------------------------------------------
// tb_monster_line_renderer
// Directed bench for monster_line_renderer. The bench drives h_cnt / v_cnt
// itself and only visits the counter ranges that matter (snapshot instant,
// the blank of the preceding line, chosen pixels), keeping runs short.
// -----------------------------------------------------------------------------
module tb_monster_line_renderer;

  logic         clk_vga = 1'b0;
  logic         rst_n;
  logic [227:0] state_monsters;
  logic [9:0]   h_cnt, v_cnt;
  logic         monster_hit;
  logic [1:0]   monster_dir;
  logic [3:0]   monster_col, monster_row;
  logic         line_overflow;
`ifdef LINE_OVERFLOW_STAT_EN
  logic [7:0]   overflow_lines;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_vga = ~clk_vga;

  monster_line_renderer dut (
    .clk_vga        (clk_vga),
    .rst_n          (rst_n),
    .state_monsters (state_monsters),
    .h_cnt          (h_cnt),
    .v_cnt          (v_cnt),
    .monster_hit    (monster_hit),
    .monster_dir    (monster_dir),
    .monster_col    (monster_col),
    .monster_row    (monster_row),
    .line_overflow  (line_overflow)
`ifdef LINE_OVERFLOW_STAT_EN
    ,
    .overflow_lines (overflow_lines)
`endif
  );

  // ---------------- helpers (stimulus and value packing only) ----------------
  function automatic logic [18:0] make_slot(input logic v, input logic [1:0] d,
                                            input logic [7:0] x, input logic [7:0] y);
    return {y, x, d, v};
  endfunction

  function automatic logic [10:0] exp_pix(input logic hit, input logic [1:0] d,
                                          input logic [3:0] col, input logic [3:0] row);
    return {hit, d, col, row};
  endfunction

  function automatic logic [10:0] pix_obs();
    return {monster_hit, monster_dir, monster_col, monster_row};
  endfunction

  task automatic set_slot(input int i, input logic [18:0] s);
    state_monsters[i*19 +: 19] = s;
  endtask

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  // Snapshot instant, then the rest of that blank (scan of line 0 and swap).
  task automatic do_snapshot();
    v_cnt = 10'd524;
    for (int h = 640; h < 800; h++) begin
      h_cnt = 10'(h);
      tick();
    end
  endtask

  // Blank interval of line l-1: builds and swaps in the list for line l.
  task automatic prep_line(input int l);
    v_cnt = 10'(l - 1);
    for (int h = 640; h < 800; h++) begin
      h_cnt = 10'(h);
      tick();
    end
  endtask

  task automatic pix(input int l, input int h);
    v_cnt = 10'(l);
    h_cnt = 10'(h);
    tick();
  endtask

  // ---------------------------------------------------------------- tests ----
  task automatic test_reset();
    rst_n = 1'b0;
    state_monsters = '0;
    h_cnt = '0;
    v_cnt = '0;
    repeat (3) tick();
    n_checks++;
    if ({pix_obs(), line_overflow} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 000", {pix_obs(), line_overflow});
    end
`ifdef LINE_OVERFLOW_STAT_EN
    n_checks++;
    if (overflow_lines !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_overflow_lines: got %0d expected 0", overflow_lines);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_sprite();
    int lines [3] = '{334, 341, 349};
    int cols  [5] = '{145, 146, 153, 161, 162};
    logic [10:0] e;
    state_monsters = '0;
    set_slot(0, make_slot(1'b1, 2'd0, 8'd73, 8'd167));
    do_snapshot();
    foreach (lines[li]) begin
      prep_line(lines[li]);
      foreach (cols[ci]) begin
        pix(lines[li], cols[ci]);
        if (cols[ci] >= 146 && cols[ci] <= 161)
          e = exp_pix(1'b1, 2'd0, 4'(cols[ci] - 146), 4'(lines[li] - 334));
        else
          e = '0;
        n_checks++;
        if (pix_obs() !== e) begin
          n_fail++;
          $display("FAIL single_l%0d_h%0d: got %h expected %h", lines[li], cols[ci], pix_obs(), e);
        end
      end
    end
    prep_line(350);
    pix(350, 150);
    n_checks++;
    if (pix_obs() !== 11'h0) begin
      n_fail++;
      $display("FAIL single_below_l350: got %h expected 000", pix_obs());
    end
  endtask

  task automatic test_overflow();
    int xs [5] = '{14, 34, 54, 91, 111};
    state_monsters = '0;
    foreach (xs[i]) set_slot(i, make_slot(1'b1, 2'(i % 4), 8'(xs[i]), 8'd105));
    do_snapshot();
    n_checks++;
    if (line_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_after_snapshot: got %b expected 0", line_overflow);
    end
    prep_line(210);
    n_checks++;
    if (line_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_l210: got %b expected 1", line_overflow);
    end
    pix(210, 28);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd0, 4'd0, 4'd0)) begin
      n_fail++;
      $display("FAIL ovf_slot0: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd0, 4'd0, 4'd0));
    end
    pix(210, 75);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd1, 4'd7, 4'd0)) begin
      n_fail++;
      $display("FAIL ovf_slot1: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd1, 4'd7, 4'd0));
    end
    pix(210, 187);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd3, 4'd5, 4'd0)) begin
      n_fail++;
      $display("FAIL ovf_slot3: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd3, 4'd5, 4'd0));
    end
    pix(210, 222);
    n_checks++;
    if (pix_obs() !== 11'h0) begin
      n_fail++;
      $display("FAIL ovf_slot4_dropped: got %h expected 000", pix_obs());
    end
    // Fix the bus: the flag must stay set until the next snapshot.
    set_slot(4, make_slot(1'b0, 2'd0, 8'd111, 8'd105));
    prep_line(211);
    n_checks++;
    if (line_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b expected 1", line_overflow);
    end
    do_snapshot();
    n_checks++;
    if (line_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared: got %b expected 0", line_overflow);
    end
    // Exactly four candidates fill the list without overflowing.
    prep_line(210);
    n_checks++;
    if (line_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_exact_four: got %b expected 0", line_overflow);
    end
    pix(210, 190);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd3, 4'd8, 4'd0)) begin
      n_fail++;
      $display("FAIL four_slot3: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd3, 4'd8, 4'd0));
    end
  endtask

  task automatic test_priority();
    state_monsters = '0;
    set_slot(2, make_slot(1'b1, 2'd3, 8'd73, 8'd105));
    set_slot(5, make_slot(1'b1, 2'd2, 8'd73, 8'd105));
    do_snapshot();
    prep_line(212);
    pix(212, 150);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd3, 4'd4, 4'd2)) begin
      n_fail++;
      $display("FAIL prio_h150: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd3, 4'd4, 4'd2));
    end
    pix(212, 161);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd3, 4'd15, 4'd2)) begin
      n_fail++;
      $display("FAIL prio_h161: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd3, 4'd15, 4'd2));
    end
  endtask

  task automatic test_mid_frame_change();
    state_monsters = '0;
    set_slot(0, make_slot(1'b1, 2'd0, 8'd73, 8'd167));
    do_snapshot();
    prep_line(334);
    pix(334, 150);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd0, 4'd4, 4'd0)) begin
      n_fail++;
      $display("FAIL mid_before: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd0, 4'd4, 4'd0));
    end
    set_slot(0, make_slot(1'b1, 2'd0, 8'd73, 8'd147));
    prep_line(340);
    pix(340, 150);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd0, 4'd4, 4'd6)) begin
      n_fail++;
      $display("FAIL mid_old_pos: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd0, 4'd4, 4'd6));
    end
    prep_line(294);
    pix(294, 150);
    n_checks++;
    if (pix_obs() !== 11'h0) begin
      n_fail++;
      $display("FAIL mid_new_pos_early: got %h expected 000", pix_obs());
    end
    do_snapshot();
    prep_line(294);
    pix(294, 150);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd0, 4'd4, 4'd0)) begin
      n_fail++;
      $display("FAIL mid_new_pos: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd0, 4'd4, 4'd0));
    end
    prep_line(334);
    pix(334, 150);
    n_checks++;
    if (pix_obs() !== 11'h0) begin
      n_fail++;
      $display("FAIL mid_old_gone: got %h expected 000", pix_obs());
    end
  endtask

  task automatic test_async_reset();
    state_monsters = '0;
    set_slot(0, make_slot(1'b1, 2'd0, 8'd73, 8'd167));
    do_snapshot();
    prep_line(340);
    pix(340, 150);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd0, 4'd4, 4'd6)) begin
      n_fail++;
      $display("FAIL arst_pre: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd0, 4'd4, 4'd6));
    end
    @(negedge clk_vga);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pix_obs(), line_overflow} !== 12'h000) begin
      n_fail++;
      $display("FAIL arst_async: got %h expected 000", {pix_obs(), line_overflow});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    prep_line(340);
    pix(340, 150);
    n_checks++;
    if (pix_obs() !== 11'h0) begin
      n_fail++;
      $display("FAIL arst_no_hit: got %h expected 000", pix_obs());
    end
    do_snapshot();
    prep_line(340);
    pix(340, 150);
    n_checks++;
    if (pix_obs() !== exp_pix(1'b1, 2'd0, 4'd4, 4'd6)) begin
      n_fail++;
      $display("FAIL arst_recover: got %h expected %h", pix_obs(), exp_pix(1'b1, 2'd0, 4'd4, 4'd6));
    end
  endtask

`ifdef LINE_OVERFLOW_STAT_EN
  task automatic test_overflow_stat();
    int xs [5] = '{14, 34, 54, 91, 111};
    state_monsters = '0;
    foreach (xs[i]) set_slot(i, make_slot(1'b1, 2'(i % 4), 8'(xs[i]), 8'd105));
    do_snapshot();
    for (int l = 205; l < 230; l++) prep_line(l);
    do_snapshot();
    n_checks++;
    if (overflow_lines !== 8'd16) begin
      n_fail++;
      $display("FAIL stat_lines: got %0d expected 16", overflow_lines);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_sprite();
    test_overflow();
    test_priority();
    test_mid_frame_change();
    test_async_reset();
`ifdef LINE_OVERFLOW_STAT_EN
    test_overflow_stat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
